btn_debouncer: RTL and testbench
================================

# btn_debouncer

- Conditions one raw pushbutton for the control logic.
- Sits directly downstream of the clock divider and consumes its slow square-wave output as a sampling strobe.
- Synchronises the button, debounces it over a configurable number of consecutive slow-clock samples, and produces:
  - a clean level,
  - a one-cycle press pulse,
  - a one-cycle release pulse.
- All logic runs in the fast system clock domain; the slow clock is never used as a clock.

## Interface
Parameters:
- STABLE_SAMPLES, default 4: consecutive agreeing samples required to accept a press or a release; legal range 1..255.
- REPEAT_DELAY, default 50: slow-clock samples held before the first auto-repeat pulse (used only with BTN_AUTOREPEAT_EN).
- REPEAT_RATE, default 10: slow-clock samples between later auto-repeat pulses (used only with BTN_AUTOREPEAT_EN).

Ports:
- clk  in  1  system clock; one clock for the whole block.
- rst  in  1  reset; asynchronous, active-high.
- slow_clk  in  1  divided clock level from the clock divider, driven from a flop clocked by clk.
- btn_in  in  1  raw button, asynchronous, bouncing.
- btn_level  out  1  debounced button state.
- btn_pulse  out  1  one-cycle strobe on an accepted press (and on auto-repeat).
- btn_release  out  1  one-cycle strobe on an accepted release.

## Operation
- btn_in passes through a 2-flop synchroniser, giving btn_s.
- slow_clk is registered once into slow_q. tick = slow_clk & ~slow_q, so tick is high for exactly one clk cycle per slow_clk rising edge.
- The state machine and counters change only in cycles where tick=1, except for clearing the pulse outputs.
- States and transitions (cnt is the sample counter, 8 bits):
  - IDLE:
    - tick & btn_s → ARMING with cnt=1.
    - If STABLE_SAMPLES==1, go straight to HELD with press actions.
  - ARMING:
    - tick & btn_s → cnt+1. When cnt+1==STABLE_SAMPLES → HELD, cnt=0, btn_pulse.
    - tick & !btn_s → IDLE, cnt=0.
  - HELD:
    - tick & !btn_s → RELEASING with cnt=1.
    - If STABLE_SAMPLES==1, go straight to IDLE with release actions.
  - RELEASING:
    - tick & !btn_s → cnt+1. When cnt+1==STABLE_SAMPLES → IDLE, cnt=0, btn_release.
    - tick & btn_s → HELD, cnt=0, with no pulse.
- btn_level is a registered output: 1 in HELD and RELEASING, 0 in IDLE and ARMING.
- btn_pulse and btn_release are registered. Each is high for exactly one clk cycle and is never high in two consecutive cycles.
- Reset values: state IDLE, cnt 0, synchroniser 0, slow_q 0, btn_level 0, btn_pulse 0, btn_release 0.
- Reset mid-press:
  - All outputs drop asynchronously.
  - After reset, a button that is still held must again be stable for STABLE_SAMPLES ticks before btn_pulse fires.
  - If slow_clk=1 in the first cycle after reset, that cycle is a tick.

## Timing
- Press latency: btn_pulse and the btn_level rise occur in the clk cycle after the tick on which the STABLE_SAMPLES-th consecutive high sample is taken.
- Release latency is symmetric and applies to btn_release and the btn_level fall.
- Sampling sees btn_in 2 clk cycles late because of the synchroniser.
- If btn_s changes in the same cycle as a tick, the tick samples the new btn_s value.
- Glitches shorter than one slow_clk period that fall between ticks are invisible.

## Configuration
- Macro: BTN_AUTOREPEAT_EN.
- When defined:
  - An 8-bit repeat counter counts ticks while in HELD.
  - btn_pulse fires again REPEAT_DELAY ticks after entering HELD, then every REPEAT_RATE ticks.
  - The repeat counter clears whenever the state is not HELD.
  - A pulse issued on the tick that moves HELD→RELEASING is suppressed.
- When undefined: exactly one btn_pulse per accepted press, and the repeat counter and parameters are not synthesised.

## Structure
- Shared package btn_pkg holds:
  - the state encoding (IDLE=2'd0, ARMING=2'd1, HELD=2'd2, RELEASING=2'd3),
  - the counter width constant CNT_W=8.
- One sub-module, slow_tick_detect (clk, rst, slow_clk → tick), holds slow_q and the edge logic. The divider-facing edge detection can then be reused by other consumers of the slow clock.

## Test plan
Bench setup for all cases: clock divider with n=2, so a tick occurs every 4 clk cycles; STABLE_SAMPLES=4.
- Clean press: hold btn_in=1 for 40 cycles → exactly one btn_pulse, 1 cycle after the 4th tick; btn_level=1 from that cycle on.
- Bounce: toggle btn_in so it is high for 3 ticks, low for 1 tick, then high for 4 ticks → single btn_pulse after the 8th tick, none earlier.
- Release: release after the accepted press → btn_release 1 cycle after the 4th low tick; btn_level=0 at that cycle; no btn_pulse during release.
- Release bounce: low for 2 ticks, high for 1 tick, low for 4 ticks → btn_level stays 1 until after the last 4 low ticks; exactly one btn_release.
- Reset mid-press: assert rst during ARMING and again during HELD with btn_in held at 1 → outputs 0 immediately; after reset, btn_pulse 1 cycle after the 4th tick.
- With BTN_AUTOREPEAT_EN, REPEAT_DELAY=5, REPEAT_RATE=2, hold for 15 ticks after acceptance → btn_pulse at acceptance, then at +5, +7, +9, +11, +13 and +15 ticks.

Source files
------------

// File: rtl/btn_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the button debouncer: FSM state encoding, counter width,
// and a range check for the sample-count parameters.
package btn_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    HELD      = 2'd2,
    RELEASING = 2'd3
  } btn_state_t;

  // Sample counts must be non-zero and fit the counter without wrapping.
  function automatic bit cnt_in_range(input int value);
    return (value >= 1) && (value < (1 << CNT_W));
  endfunction

endpackage

// File: rtl/slow_tick_detect.sv
`timescale 1ns/1ps
// Turns the divider's slow square wave into a one-clk-cycle tick on each rising edge.
// The slow clock is only ever sampled as data in the clk domain.
module slow_tick_detect (
  input  logic clk,
  input  logic rst,
  input  logic slow_clk,
  output logic tick
);

  logic slow_q;

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slow_q <= 1'b0;
    end else begin
      slow_q <= slow_clk;
    end
  end

  assign tick = slow_clk & ~slow_q;

endmodule

// File: rtl/btn_debouncer.sv
`timescale 1ns/1ps
// Pushbutton conditioner: 2-flop synchroniser, tick-sampled debounce FSM, registered
// level/press/release outputs. Define BTN_AUTOREPEAT_EN to re-fire btn_pulse while held.
module btn_debouncer
  import btn_pkg::*;
#(
  parameter int STABLE_SAMPLES = 4,
  parameter int REPEAT_DELAY   = 50,
  parameter int REPEAT_RATE    = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic slow_clk,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_pulse,
  output logic btn_release
);

  localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_SAMPLES);
  // An out-of-range configuration never samples: a dead button instead of wrapping counters.
  localparam bit CFG_OK = cnt_in_range(STABLE_SAMPLES) && cnt_in_range(REPEAT_DELAY) &&
                          cnt_in_range(REPEAT_RATE);

  logic             tick;
  logic             sample;
  logic             sync1;
  logic             btn_s;
  btn_state_t       state;
  btn_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             press_ev;
  logic             release_ev;
  logic             rep_fire;
  logic             level_nxt;
  logic             pulse_nxt;
  logic             release_nxt;

  slow_tick_detect u_tick (
    .clk      (clk),
    .rst      (rst),
    .slow_clk (slow_clk),
    .tick     (tick)
  );

  assign sample  = tick & CFG_OK;
  assign cnt_inc = cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync1 <= btn_in;
      btn_s <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_pulse   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      btn_level   <= level_nxt;
      btn_pulse   <= pulse_nxt;
      btn_release <= release_nxt;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_nxt  = state;
    cnt_nxt    = cnt;
    press_ev   = 1'b0;
    release_ev = 1'b0;
    if (sample) begin
      unique case (state)
        IDLE: begin
          if (btn_s) begin
            if (STABLE == CNT_W'(1)) begin
              state_nxt = HELD;
              cnt_nxt   = '0;
              press_ev  = 1'b1;
            end else begin
              state_nxt = ARMING;
              cnt_nxt   = CNT_W'(1);
            end
          end
        end
        ARMING: begin
          if (!btn_s) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt_inc == STABLE) begin
            state_nxt = HELD;
            cnt_nxt   = '0;
            press_ev  = 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        HELD: begin
          if (!btn_s) begin
            if (STABLE == CNT_W'(1)) begin
              state_nxt  = IDLE;
              cnt_nxt    = '0;
              release_ev = 1'b1;
            end else begin
              state_nxt = RELEASING;
              cnt_nxt   = CNT_W'(1);
            end
          end
        end
        RELEASING: begin
          if (btn_s) begin
            state_nxt = HELD;
            cnt_nxt   = '0;
          end else if (cnt_inc == STABLE) begin
            state_nxt  = IDLE;
            cnt_nxt    = '0;
            release_ev = 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      endcase
    end
  end

  always_comb begin
    level_nxt   = (state_nxt == HELD) || (state_nxt == RELEASING);
    pulse_nxt   = press_ev | rep_fire;
    release_nxt = release_ev;
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_DELAY = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] REP_RATE  = CNT_W'(REPEAT_RATE);

  logic [CNT_W-1:0] rep_cnt;
  logic [CNT_W-1:0] rep_cnt_nxt;
  logic [CNT_W-1:0] rep_inc;
  logic             rep_phase;
  logic             rep_phase_nxt;

  assign rep_inc = rep_cnt + CNT_W'(1);

  // rep_phase selects the initial delay (0) or the steady repeat interval (1).
  always_comb begin
    rep_cnt_nxt   = rep_cnt;
    rep_phase_nxt = rep_phase;
    rep_fire      = 1'b0;
    if (state != HELD) begin
      rep_cnt_nxt   = '0;
      rep_phase_nxt = 1'b0;
    end else if (sample && btn_s) begin
      if (rep_inc == (rep_phase ? REP_RATE : REP_DELAY)) begin
        rep_fire      = 1'b1;
        rep_cnt_nxt   = '0;
        rep_phase_nxt = 1'b1;
      end else begin
        rep_cnt_nxt = rep_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
    end else begin
      rep_cnt   <= rep_cnt_nxt;
      rep_phase <= rep_phase_nxt;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debouncer.sv
`timescale 1ns/1ps
// Bench for btn_debouncer: divide-by-4 slow clock (one tick per 4 clk cycles), STABLE_SAMPLES=4.
// Each step holds btn_in for one tick period and checks the outputs in the cycle after that tick.
module tb_btn_debouncer;

`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  typedef struct {
    logic       btn;
    logic [2:0] want;  // {btn_level, btn_pulse, btn_release}
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       slow_clk;
  logic       btn_in;
  logic       btn_level;
  logic       btn_pulse;
  logic       btn_release;
  logic [1:0] div_cnt = 2'd0;
  logic [2:0] outs;

  int checks    = 0;
  int failures  = 0;
  int n_pulse   = 0;
  int n_release = 0;
  int base_p;
  int base_r;

  vec_t tbl [31];

  btn_debouncer #(
    .STABLE_SAMPLES (4),
    .REPEAT_DELAY   (5),
    .REPEAT_RATE    (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .slow_clk    (slow_clk),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_pulse   (btn_pulse),
    .btn_release (btn_release)
  );

  always #5 clk = ~clk;

  always @(posedge clk) div_cnt <= div_cnt + 2'd1;
  assign slow_clk = div_cnt[1];
  assign outs     = {btn_level, btn_pulse, btn_release};

  // Counts strobes seen during the cycle that ends at each edge.
  always @(posedge clk) begin
    if (btn_pulse)   n_pulse++;
    if (btn_release) n_release++;
  end

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: level/pulse/release got %b expected %b", name, act, want);
    end
  endtask

  task automatic check_int(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  // Called just after a negedge that follows a tick edge; returns at the same phase one period later.
  task automatic run_tick(input logic b, input logic [2:0] want, input string name);
    btn_in = b;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check(name, outs, want);
  endtask

  task automatic apply_reset(input string name);
    rst = 1'b1;
    #1;
    check(name, outs, 3'b000);
    repeat (4) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle_period();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl = '{
      // clean press, held 10 ticks (40 cycles); auto-repeat would fire at +5
      '{1'b1, 3'b000}, '{1'b1, 3'b000}, '{1'b1, 3'b000}, '{1'b1, 3'b110},
      '{1'b1, 3'b100}, '{1'b1, 3'b100}, '{1'b1, 3'b100}, '{1'b1, 3'b100},
      '{1'b1, {1'b1, AR, 1'b0}}, '{1'b1, 3'b100},
      // release; an auto-repeat due on the leaving tick is suppressed
      '{1'b0, 3'b100}, '{1'b0, 3'b100}, '{1'b0, 3'b100}, '{1'b0, 3'b001},
      '{1'b0, 3'b000},
      // bounce: high 3, low 1, high 4
      '{1'b1, 3'b000}, '{1'b1, 3'b000}, '{1'b1, 3'b000}, '{1'b0, 3'b000},
      '{1'b1, 3'b000}, '{1'b1, 3'b000}, '{1'b1, 3'b000}, '{1'b1, 3'b110},
      // release bounce: low 2, high 1, low 4
      '{1'b0, 3'b100}, '{1'b0, 3'b100}, '{1'b1, 3'b100}, '{1'b0, 3'b100},
      '{1'b0, 3'b100}, '{1'b0, 3'b100}, '{1'b0, 3'b001}, '{1'b0, 3'b000}
    };

    rst    = 1'b1;
    btn_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", outs, 3'b000);

    // Release reset just after a tick edge so every later tick lands 4 edges apart.
    while (div_cnt != 2'd3) @(negedge clk);
    rst    = 1'b0;
    base_p = n_pulse;
    base_r = n_release;

    for (int i = 0; i < 31; i++) begin
      run_tick(tbl[i].btn, tbl[i].want, $sformatf("table[%0d]", i));
    end
    idle_period();
    check_int("table_pulse_count", n_pulse - base_p, 2 + int'(AR));
    check_int("table_release_count", n_release - base_r, 2);

    // Reset while ARMING: the count must restart from zero.
    run_tick(1'b1, 3'b000, "arming_1");
    run_tick(1'b1, 3'b000, "arming_2");
    apply_reset("reset_in_arming");
    for (int i = 0; i < 4; i++) begin
      run_tick(1'b1, (i == 3) ? 3'b110 : 3'b000, $sformatf("after_reset_a[%0d]", i));
    end

    // Reset in HELD while btn_pulse is high: outputs drop without waiting for a clock.
    apply_reset("reset_in_held");
    for (int i = 0; i < 4; i++) begin
      run_tick(1'b1, (i == 3) ? 3'b110 : 3'b000, $sformatf("after_reset_b[%0d]", i));
    end

    // Hold 15 ticks after acceptance: repeats at +5, +7, ... +15 only with auto-repeat.
    base_p = n_pulse;
    base_r = n_release;
    for (int k = 1; k <= 15; k++) begin
      run_tick(1'b1, {1'b1, AR && (k >= 5) && (k % 2 == 1), 1'b0}, $sformatf("hold[+%0d]", k));
    end
    for (int i = 0; i < 4; i++) begin
      run_tick(1'b0, (i == 3) ? 3'b001 : 3'b100, $sformatf("final_release[%0d]", i));
    end
    idle_period();
    check_int("hold_pulse_count", n_pulse - base_p, 1 + 6 * int'(AR));
    check_int("hold_release_count", n_release - base_r, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
